// File: rtl/cash_pkg.sv
// Shared types for the cash ledger: operation encoding, error codes and FSM states.
package cash_pkg;

    // Encoding is {mode, func} so the request fields cast directly onto it.
    typedef enum logic [1:0] {
        PURCHASE = 2'b00,
        CHARGE   = 2'b01,
        DEPOSIT  = 2'b10,
        RECEIVE  = 2'b11
    } op_e;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_INSUF    = 2'd1;
    localparam logic [1:0] ERR_OVF      = 2'd2;
    localparam logic [1:0] ERR_BAD_ACCT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

endpackage

// File: rtl/cash_check.sv
// Combinational transaction evaluator: applies the prioritised checks and
// produces the candidate new balances, which equal the old ones on any failure.
module cash_check
    import cash_pkg::*;
#(
    parameter int AMT_W = 11,
    parameter int BAL_W = 16
) (
    input  op_e              i_op,
    input  logic [AMT_W-1:0] i_amount,
    input  logic [BAL_W-1:0] i_custBal,
    input  logic [BAL_W-1:0] i_machBal,
    input  logic             i_acctOob,
    output logic             o_ok,
    output logic [1:0]       o_err,
    output logic [BAL_W-1:0] o_newCust,
    output logic [BAL_W-1:0] o_newMach
);

    logic [BAL_W-1:0] w_amt;
    logic [BAL_W:0]   w_custSum;
    logic [BAL_W:0]   w_machSum;

    // Sums carry one extra bit so the top bit flags an overflow without wrapping.
    assign w_amt     = BAL_W'(i_amount);
    assign w_custSum = {1'b0, i_custBal} + {1'b0, w_amt};
    assign w_machSum = {1'b0, i_machBal} + {1'b0, w_amt};

    always_comb begin
        o_err     = ERR_OK;
        o_newCust = i_custBal;
        o_newMach = i_machBal;
        case (i_op)
            PURCHASE: begin
                if (i_acctOob)
                    o_err = ERR_BAD_ACCT;
                else if (i_custBal < w_amt)
                    o_err = ERR_INSUF;
                else if (w_machSum[BAL_W])
                    o_err = ERR_OVF;
                else begin
                    o_newCust = i_custBal - w_amt;
                    o_newMach = w_machSum[BAL_W-1:0];
                end
            end
            CHARGE: begin
                if (i_acctOob)
                    o_err = ERR_BAD_ACCT;
                else if (w_custSum[BAL_W])
                    o_err = ERR_OVF;
                else
                    o_newCust = w_custSum[BAL_W-1:0];
            end
            RECEIVE: begin
                if (i_machBal < w_amt)
                    o_err = ERR_INSUF;
                else
                    o_newMach = i_machBal - w_amt;
            end
            DEPOSIT: begin
                if (w_machSum[BAL_W])
                    o_err = ERR_OVF;
                else
                    o_newMach = w_machSum[BAL_W-1:0];
            end
            default: o_err = ERR_OK;
        endcase
        o_ok = (o_err == ERR_OK);
    end

endmodule

// File: rtl/cash_ledger.sv
// Multi-account cash ledger: one transaction per valid/ready request, evaluated
// in EXEC and reported by a one-cycle result strobe in RESP.
module cash_ledger
    import cash_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 4,
    parameter int AMT_W        = 11,
    parameter int BAL_W        = 16,
    localparam int ACCT_W      = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mode,
    input  logic              func,
    input  logic [ACCT_W-1:0] acct,
    input  logic [AMT_W-1:0]  amount,
    output logic              res_valid,
    output logic              res,
    output logic [1:0]        err,
    output logic [BAL_W-1:0]  bal_out,
    output logic [BAL_W-1:0]  mach_balance
);

    state_e            r_state;
    op_e               r_op;
    logic [ACCT_W-1:0] r_acct;
    logic [AMT_W-1:0]  r_amount;
    logic [BAL_W-1:0]  r_cust [NUM_ACCOUNTS];
    logic [BAL_W-1:0]  r_mach;
    logic              r_reqReady;
    logic              r_resValid;
    logic              r_res;
    logic [1:0]        r_err;
    logic [BAL_W-1:0]  r_balOut;

    logic              w_custMode;
    logic              w_acctOob;
    logic [BAL_W-1:0]  w_custBal;
    logic              w_ok;
    logic [1:0]        w_err;
    logic [BAL_W-1:0]  w_newCust;
    logic [BAL_W-1:0]  w_newMach;

    assign w_custMode = (r_op == PURCHASE) || (r_op == CHARGE);
    assign w_acctOob  = (32'(r_acct) >= NUM_ACCOUNTS);

    // An out-of-range index reads as zero; the evaluator rejects it anyway.
    always_comb begin
        w_custBal = '0;
        if (!w_acctOob)
            w_custBal = r_cust[r_acct];
    end

    cash_check #(
        .AMT_W (AMT_W),
        .BAL_W (BAL_W)
    ) u_check (
        .i_op      (r_op),
        .i_amount  (r_amount),
        .i_custBal (w_custBal),
        .i_machBal (r_mach),
        .i_acctOob (w_acctOob),
        .o_ok      (w_ok),
        .o_err     (w_err),
        .o_newCust (w_newCust),
        .o_newMach (w_newMach)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_op       <= PURCHASE;
            r_acct     <= '0;
            r_amount   <= '0;
            r_mach     <= '0;
            r_reqReady <= 1'b1;
            r_resValid <= 1'b0;
            r_res      <= 1'b0;
            r_err      <= ERR_OK;
            r_balOut   <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++)
                r_cust[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_reqReady) begin
                        r_op       <= op_e'({mode, func});
                        r_acct     <= acct;
                        r_amount   <= amount;
                        r_reqReady <= 1'b0;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    r_resValid <= 1'b1;
                    r_res      <= w_ok;
                    r_err      <= w_err;
                    r_balOut   <= w_custMode ? w_newCust : w_newMach;
                    // Both sides of a purchase commit on the same edge, or neither does.
                    if (w_ok) begin
                        r_mach <= w_newMach;
                        for (int i = 0; i < NUM_ACCOUNTS; i++)
                            if (w_custMode && (ACCT_W'(i) == r_acct))
                                r_cust[i] <= w_newCust;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_resValid <= 1'b0;
                    r_reqReady <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_reqReady <= 1'b1;
                    r_resValid <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_reqReady;
    assign res_valid    = r_resValid;
    assign res          = r_res;
    assign err          = r_err;
    assign bal_out      = r_balOut;
    assign mach_balance = r_mach;

endmodule

// File: tb/tb_cash_ledger.sv
// Self-checking bench for cash_ledger: directed boundary steps then random
// transactions, each compared against an arithmetic model of the ledger.
module tb_cash_ledger;

    localparam int NUM_ACCOUNTS = 3;
    localparam int AMT_W        = 11;
    localparam int BAL_W        = 11;
    localparam int ACCT_W       = 2;
    localparam int MAX_BAL      = (1 << BAL_W) - 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              mode;
    logic              func;
    logic [ACCT_W-1:0] acct;
    logic [AMT_W-1:0]  amount;
    logic              res_valid;
    logic              res;
    logic [1:0]        err;
    logic [BAL_W-1:0]  bal_out;
    logic [BAL_W-1:0]  mach_balance;

    int testsRun    = 0;
    int testsFailed = 0;
    int custModel [NUM_ACCOUNTS];
    int machModel;

    cash_ledger #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .AMT_W        (AMT_W),
        .BAL_W        (BAL_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mode         (mode),
        .func         (func),
        .acct         (acct),
        .amount       (amount),
        .res_valid    (res_valid),
        .res          (res),
        .err          (err),
        .bal_out      (bal_out),
        .mach_balance (mach_balance)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        assert (got === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Ledger rules expressed directly on integer balances.
    task automatic modelTxn(input logic m, input logic f, input int a, input int amt,
                            output int expRes, output int expErr, output int expBal,
                            output bit balKnown);
        expRes   = 0;
        expErr   = 0;
        expBal   = 0;
        balKnown = 1'b1;
        if (!m && a >= NUM_ACCOUNTS) begin
            expErr   = 3;
            balKnown = 1'b0;
        end else if (!m && !f) begin
            if (custModel[a] < amt)
                expErr = 1;
            else if (machModel + amt > MAX_BAL)
                expErr = 2;
            else begin
                custModel[a] -= amt;
                machModel    += amt;
            end
            expBal = custModel[a];
        end else if (!m && f) begin
            if (custModel[a] + amt > MAX_BAL)
                expErr = 2;
            else
                custModel[a] += amt;
            expBal = custModel[a];
        end else if (m && f) begin
            if (machModel < amt)
                expErr = 1;
            else
                machModel -= amt;
            expBal = machModel;
        end else begin
            if (machModel + amt > MAX_BAL)
                expErr = 2;
            else
                machModel += amt;
            expBal = machModel;
        end
        expRes = (expErr == 0) ? 1 : 0;
    endtask

    // Presents a request, waits (bounded) for acceptance, then scrambles the
    // request fields while req_valid stays high to show they are ignored.
    task automatic applyStimulus(input logic m, input logic f, input int a, input int amt);
        int waitCount;
        waitCount = 0;
        @(negedge clock);
        req_valid = 1'b1;
        mode      = m;
        func      = f;
        acct      = ACCT_W'(a);
        amount    = AMT_W'(amt);
        while (req_ready !== 1'b1 && waitCount < 10) begin
            @(negedge clock);
            waitCount++;
        end
        check("acceptWithinBound", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        mode   = 1'($urandom);
        func   = 1'($urandom);
        acct   = ACCT_W'($urandom);
        amount = AMT_W'($urandom);
        @(negedge clock);
        check("readyLowInExec", 32'(req_ready), 32'd0);
        check("noResultInExec", 32'(res_valid), 32'd0);
    endtask

    task automatic checkOutput(input int expRes, input int expErr, input int expBal, input bit balKnown);
        @(negedge clock);
        check("resValidInResp", 32'(res_valid), 32'd1);
        check("readyLowInResp", 32'(req_ready), 32'd0);
        check("res", 32'(res), 32'(expRes));
        check("err", 32'(err), 32'(expErr));
        if (balKnown)
            check("balOut", 32'(bal_out), 32'(expBal));
        check("machBalance", 32'(mach_balance), 32'(machModel));
        @(negedge clock);
        req_valid = 1'b0;
        check("resValidStrobe", 32'(res_valid), 32'd0);
        check("readyAgain", 32'(req_ready), 32'd1);
        check("resHeld", 32'(res), 32'(expRes));
        check("errHeld", 32'(err), 32'(expErr));
    endtask

    task automatic runTxn(input logic m, input logic f, input int a, input int amt);
        int  expRes, expErr, expBal;
        bit  balKnown;
        modelTxn(m, f, a, amt, expRes, expErr, expBal, balKnown);
        applyStimulus(m, f, a, amt);
        checkOutput(expRes, expErr, expBal, balKnown);
    endtask

    initial begin
        int pick, rm, rf, ra, ramt;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        mode      = 1'b0;
        func      = 1'b0;
        acct      = '0;
        amount    = '0;
        machModel = 0;
        for (int i = 0; i < NUM_ACCOUNTS; i++)
            custModel[i] = 0;

        repeat (3) @(negedge clock);
        check("resetReady", 32'(req_ready), 32'd1);
        check("resetResValid", 32'(res_valid), 32'd0);
        check("resetRes", 32'(res), 32'd0);
        check("resetErr", 32'(err), 32'd0);
        check("resetBalOut", 32'(bal_out), 32'd0);
        check("resetMach", 32'(mach_balance), 32'd0);
        reset_n = 1'b1;

        runTxn(1'b0, 1'b1, 1, 7);
        runTxn(1'b0, 1'b0, 1, 3);
        runTxn(1'b0, 1'b0, 1, 5);
        runTxn(1'b1, 1'b0, 0, 10);
        runTxn(1'b1, 1'b1, 0, 13);
        runTxn(1'b1, 1'b1, 0, 1);
        runTxn(1'b0, 1'b1, 0, 2047);
        runTxn(1'b0, 1'b1, 0, 1);
        runTxn(1'b0, 1'b1, 3, 4);
        runTxn(1'b0, 1'b0, 3, 0);
        runTxn(1'b0, 1'b0, 2, 0);
        runTxn(1'b1, 1'b0, 0, 2047);
        runTxn(1'b0, 1'b0, 0, 1);
        runTxn(1'b1, 1'b1, 0, 2047);
        runTxn(1'b0, 1'b0, 0, 2047);

        // Abort a CHARGE while it sits in EXEC.
        applyStimulus(1'b0, 1'b1, 2, 5);
        reset_n   = 1'b0;
        req_valid = 1'b0;
        #2;
        check("abortNoResult", 32'(res_valid), 32'd0);
        check("abortReady", 32'(req_ready), 32'd1);
        check("abortMachCleared", 32'(mach_balance), 32'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        machModel = 0;
        for (int i = 0; i < NUM_ACCOUNTS; i++)
            custModel[i] = 0;
        repeat (2) begin
            @(negedge clock);
            check("abortStaysQuiet", 32'(res_valid), 32'd0);
        end
        for (int i = 0; i < NUM_ACCOUNTS; i++)
            runTxn(1'b0, 1'b1, i, 0);

        for (int n = 0; n < 60; n++) begin
            rm   = int'($urandom_range(0, 1));
            rf   = int'($urandom_range(0, 1));
            ra   = int'($urandom_range(0, 3));
            pick = int'($urandom_range(0, 3));
            case (pick)
                0:       ramt = 0;
                1:       ramt = int'($urandom_range(0, 300));
                2:       ramt = (rm == 1) ? machModel : ((ra < NUM_ACCOUNTS) ? custModel[ra] : 0);
                default: ramt = int'($urandom_range(0, MAX_BAL));
            endcase
            runTxn(1'(rm), 1'(rf), ra, ramt);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cash_ledger.md
Name: cash_ledger

Overview:
- Parametrised successor to the single-user cash handler.
- Keeps NUM_ACCOUNTS customer balances plus one machine balance in registers and executes one transaction per request over a valid/ready handshake.
- Purchases are transfers: customer balance goes down and machine balance goes up, atomically.
- Every transaction returns a registered pass/fail result with an error code. Sits between the vending controller FSM and the coin/note front end.

Parameters:
- NUM_ACCOUNTS, 4, number of customer balances; must be >= 1.
- AMT_W, 11, width of the transaction amount.
- BAL_W, 16, width of each balance register; must be >= AMT_W.
- ACCT_W (localparam), max(1, $clog2(NUM_ACCOUNTS)), account index width.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- mode  in  1  0 = customer, 1 = machine.
- func  in  1  operation select within mode (see Behaviour).
- acct  in  ACCT_W  customer account index; ignored when mode=1.
- amount  in  AMT_W  transaction amount, unsigned.
- res_valid  out  1  one-cycle result strobe.
- res  out  1  1 = success; valid only with res_valid.
- err  out  2  0 OK, 1 INSUFFICIENT, 2 OVERFLOW, 3 BAD_ACCT.
- bal_out  out  BAL_W  post-transaction balance of the affected account (machine balance when mode=1).
- mach_balance  out  BAL_W  current machine balance, always driven.

Behaviour:
- Reset (async, reset_n=0):
  - all balances = 0.
  - state = IDLE, req_ready = 1.
  - res_valid = 0, res = 0, err = 0, bal_out = 0.
- Operations:
  - mode0/func0 PURCHASE: cust[acct] -= amount and mach += amount.
  - mode0/func1 CHARGE: cust[acct] += amount.
  - mode1/func1 RECEIVE (cash collected from machine): mach -= amount.
  - mode1/func0 DEPOSIT: mach += amount.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready = 1. On req_valid & req_ready at edge T, latch mode/func/acct/amount and go to EXEC.
  - EXEC (T+1): req_ready = 0. Evaluate checks; on pass, all balance writes commit at the end of this cycle. Go to RESP.
  - RESP (T+2): res_valid = 1 for exactly one cycle with res, err and bal_out. Go to IDLE; req_ready = 1 again at T+3.
- Latency and throughput: latency 2 cycles from accept to res_valid; at most one transaction per 3 cycles.
- Request handling: no queuing. Inputs while req_ready = 0 are ignored; the requester holds req_valid until accepted.
- Checks, in priority order:
  - BAD_ACCT: mode=0 and acct >= NUM_ACCOUNTS (only possible when NUM_ACCOUNTS is not a power of 2).
  - INSUFFICIENT: the subtracted balance < amount.
  - OVERFLOW: an added balance + amount > 2^BAL_W - 1, computed at BAL_W+1 bits.
- Failure: no balance changes at all (PURCHASE is all-or-nothing), res = 0, bal_out = the unchanged balance.
- Boundaries:
  - amount = 0 always succeeds with no change.
  - Exact drain (balance == amount) succeeds, leaving 0.
  - Exact fill to 2^BAL_W - 1 succeeds.
  - No wrap-around ever occurs.
- Reset asserted in EXEC or RESP aborts the transaction: no res_valid, and balances are cleared.
- res, err and bal_out hold their last values outside res_valid; only res_valid is a strobe.
- mach_balance reflects the committed value from the cycle after EXEC.

Decomposition:
- Package cash_pkg holds:
  - op encoding enum (PURCHASE, CHARGE, RECEIVE, DEPOSIT) derived from {mode, func};
  - err code constants ERR_OK, ERR_INSUF, ERR_OVF, ERR_BAD_ACCT;
  - state enum IDLE/EXEC/RESP.
- One natural sub-module, cash_check: purely combinational. Takes latched op, amount and the source/destination balances; produces ok, err, and the new balances. Keeps the FSM file register-only.

Test Plan:
- Reset, then CHARGE acct1 amount=7 -> res_valid at T+2, res=1, err=0, bal_out=7; req_ready low at T+1..T+2.
- PURCHASE acct1 amount=3 after the previous step -> res=1, bal_out=4, mach_balance=3.
- PURCHASE acct1 amount=5 (balance 4) -> res=0, err=1; acct1 stays 4, mach stays 3.
- DEPOSIT amount=10 then RECEIVE amount=13 -> mach=13 and bal_out=13, then res=1, bal_out=0. A further RECEIVE of 1 -> err=1.
- With BAL_W=11: CHARGE acct0 2047, then CHARGE acct0 1 -> first res=1; second res=0, err=2, balance 2047. With NUM_ACCOUNTS=3, acct=3 -> err=3.
- Pulse reset_n low during EXEC of a CHARGE of 5 -> no res_valid, all balances 0, req_ready=1 after release.
